// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multicycle core: decodes OP/FUNCT and drives every datapath
// select and enable, with a memory-ready handshake guarded by a wait-limit watchdog.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OP,
    input  logic [5:0] FUNCT,
    input  logic       MEM_READY,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [3:0] STATE,
    output logic       ILLEGAL,
    output logic       BUS_ERR
);
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          in_mem;
    logic          expired;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        in_mem  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        expired = (WAIT_LIMIT != 0) && in_mem && !MEM_READY &&
                  (wait_cnt_q == CW'(WAIT_LIMIT));

        // Counter only runs while stalled in a memory state; any completion or exit clears it.
        wait_cnt_d = '0;
        if ((WAIT_LIMIT != 0) && in_mem && !MEM_READY && !expired)
            wait_cnt_d = wait_cnt_q + CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ILLEGAL    = 1'b0;
        BUS_ERR    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
                if (MEM_READY) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    BUS_ERR = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = 3'b010;
                case (OP)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000:            state_d = S_EXECUTE;
                    6'b000100:            state_d = S_BEQ;
                    6'b001000:            state_d = S_ADDIEXEC;
                    6'b000010:            state_d = S_JUMP;
                    default: begin
                        ILLEGAL = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                state_d    = (OP == 6'b100011) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (MEM_READY) begin
                    state_d = S_MEMWB;
                end else if (expired) begin
                    BUS_ERR = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                // An expiring store is abandoned, so the write strobe drops in that cycle.
                MemWrite = !expired;
                if (MEM_READY) begin
                    state_d = S_FETCH;
                end else if (expired) begin
                    BUS_ERR = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                state_d = S_ALUWB;
                case (FUNCT)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default: begin
                        ILLEGAL = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                Branch     = 1'b1;
                PCSrc      = 2'b01;
                state_d    = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset forces every output quiet, even though the state already reads FETCH.
        if (!RST) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            PCSrc      = 2'b00;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUControl = 3'b000;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ILLEGAL    = 1'b0;
            BUS_ERR    = 1'b0;
        end
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl (WAIT_LIMIT=4), plus an asynchronous
// reset sequence in the middle of a store.
module tb_multicycle_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] OP = 6'd0;
    logic [5:0] FUNCT = 6'd0;
    logic       MEM_READY = 1'b0;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegDst, MemtoReg, RegWrite, ILLEGAL, BUS_ERR;
    logic [3:0] STATE;
    logic [17:0] ctl;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST), .OP(OP), .FUNCT(FUNCT), .MEM_READY(MEM_READY),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .STATE(STATE), .ILLEGAL(ILLEGAL), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    // {IorD,MemWrite,IRWrite,PCWrite,Branch,PCSrc,ALUSrcA,ALUSrcB,ALUControl,RegDst,MemtoReg,RegWrite,ILLEGAL,BUS_ERR}
    assign ctl = {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
                  ALUControl, RegDst, MemtoReg, RegWrite, ILLEGAL, BUS_ERR};

    localparam logic [17:0] C_ZERO    = 18'b0_0_0_0_0_00_0_00_000_0_0_0_0_0;
    localparam logic [17:0] C_F_RDY   = 18'b0_0_1_1_0_00_0_01_010_0_0_0_0_0;
    localparam logic [17:0] C_F_WAIT  = 18'b0_0_0_0_0_00_0_01_010_0_0_0_0_0;
    localparam logic [17:0] C_F_BERR  = 18'b0_0_0_0_0_00_0_01_010_0_0_0_0_1;
    localparam logic [17:0] C_DEC     = 18'b0_0_0_0_0_00_0_11_010_0_0_0_0_0;
    localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_00_0_11_010_0_0_0_1_0;
    localparam logic [17:0] C_ADR     = 18'b0_0_0_0_0_00_1_10_010_0_0_0_0_0;
    localparam logic [17:0] C_MRD     = 18'b1_0_0_0_0_00_0_00_000_0_0_0_0_0;
    localparam logic [17:0] C_MWB     = 18'b0_0_0_0_0_00_0_00_000_0_1_1_0_0;
    localparam logic [17:0] C_MWR     = 18'b1_1_0_0_0_00_0_00_000_0_0_0_0_0;
    localparam logic [17:0] C_EX_SUB  = 18'b0_0_0_0_0_00_1_00_110_0_0_0_0_0;
    localparam logic [17:0] C_EX_AND  = 18'b0_0_0_0_0_00_1_00_000_0_0_0_0_0;
    localparam logic [17:0] C_EX_SLT  = 18'b0_0_0_0_0_00_1_00_111_0_0_0_0_0;
    localparam logic [17:0] C_EX_ILL  = 18'b0_0_0_0_0_00_1_00_000_0_0_0_1_0;
    localparam logic [17:0] C_AWB     = 18'b0_0_0_0_0_00_0_00_000_1_0_1_0_0;
    localparam logic [17:0] C_BEQ     = 18'b0_0_0_0_1_01_1_00_110_0_0_0_0_0;
    localparam logic [17:0] C_JMP     = 18'b0_0_0_1_0_10_0_00_000_0_0_0_0_0;
    localparam logic [17:0] C_IWB     = 18'b0_0_0_0_0_00_0_00_000_0_0_1_0_0;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctl;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] op, input logic [5:0] funct, input logic rdy,
                       input logic [3:0] st, input logic [17:0] c, input string name);
        vec_t v;
        v.op = op; v.funct = funct; v.rdy = rdy; v.st = st; v.ctl = c; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [3:0] exp_st, input logic [17:0] exp_ctl);
        checks++;
        if (STATE !== exp_st) begin
            errors++;
            $display("FAIL %s state: got %0d, expected %0d", name, STATE, exp_st);
        end
        checks++;
        if (ctl !== exp_ctl) begin
            errors++;
            $display("FAIL %s outputs: got %b, expected %b", name, ctl, exp_ctl);
        end
    endtask

    task automatic cycle(input logic [5:0] op, input logic [5:0] funct, input logic rdy,
                         input logic [3:0] st, input logic [17:0] c, input string name);
        @(negedge CLK);
        OP = op; FUNCT = funct; MEM_READY = rdy;
        #1;
        compare(name, st, c);
        $display("cycle %-14s op=%b funct=%b rdy=%b state=%0d ctl=%b", name, op, funct, rdy, STATE, ctl);
    endtask

    initial begin
        // lw with one memory wait in MEMRD
        add(OP_LW, 6'd0, 1'b1, 4'd0, C_F_RDY, "lw_fetch");
        add(OP_LW, 6'd0, 1'b0, 4'd1, C_DEC,   "lw_decode");
        add(OP_LW, 6'd0, 1'b0, 4'd2, C_ADR,   "lw_memadr");
        add(OP_LW, 6'd0, 1'b0, 4'd3, C_MRD,   "lw_memrd_wait");
        add(OP_LW, 6'd0, 1'b1, 4'd3, C_MRD,   "lw_memrd");
        add(OP_LW, 6'd0, 1'b0, 4'd4, C_MWB,   "lw_memwb");
        // sw with three wait cycles: MemWrite held four cycles
        add(OP_SW, 6'd0, 1'b1, 4'd0, C_F_RDY, "sw_fetch");
        add(OP_SW, 6'd0, 1'b0, 4'd1, C_DEC,   "sw_decode");
        add(OP_SW, 6'd0, 1'b0, 4'd2, C_ADR,   "sw_memadr");
        add(OP_SW, 6'd0, 1'b0, 4'd5, C_MWR,   "sw_wait1");
        add(OP_SW, 6'd0, 1'b0, 4'd5, C_MWR,   "sw_wait2");
        add(OP_SW, 6'd0, 1'b0, 4'd5, C_MWR,   "sw_wait3");
        add(OP_SW, 6'd0, 1'b1, 4'd5, C_MWR,   "sw_done");
        // R-type sub, and, slt, illegal funct
        add(OP_R, 6'b100010, 1'b1, 4'd0, C_F_RDY,  "sub_fetch");
        add(OP_R, 6'b100010, 1'b0, 4'd1, C_DEC,    "sub_decode");
        add(OP_R, 6'b100010, 1'b0, 4'd6, C_EX_SUB, "sub_exec");
        add(OP_R, 6'b100010, 1'b0, 4'd7, C_AWB,    "sub_aluwb");
        add(OP_R, 6'b100100, 1'b1, 4'd0, C_F_RDY,  "and_fetch");
        add(OP_R, 6'b100100, 1'b0, 4'd1, C_DEC,    "and_decode");
        add(OP_R, 6'b100100, 1'b0, 4'd6, C_EX_AND, "and_exec");
        add(OP_R, 6'b100100, 1'b0, 4'd7, C_AWB,    "and_aluwb");
        add(OP_R, 6'b101010, 1'b1, 4'd0, C_F_RDY,  "slt_fetch");
        add(OP_R, 6'b101010, 1'b0, 4'd1, C_DEC,    "slt_decode");
        add(OP_R, 6'b101010, 1'b0, 4'd6, C_EX_SLT, "slt_exec");
        add(OP_R, 6'b101010, 1'b0, 4'd7, C_AWB,    "slt_aluwb");
        add(OP_R, 6'b001000, 1'b1, 4'd0, C_F_RDY,  "badf_fetch");
        add(OP_R, 6'b001000, 1'b0, 4'd1, C_DEC,    "badf_decode");
        add(OP_R, 6'b001000, 1'b0, 4'd6, C_EX_ILL, "badf_exec");
        // beq, addi, j
        add(OP_BEQ, 6'd0, 1'b1, 4'd0, C_F_RDY,  "beq_fetch");
        add(OP_BEQ, 6'd0, 1'b0, 4'd1, C_DEC,    "beq_decode");
        add(OP_BEQ, 6'd0, 1'b0, 4'd8, C_BEQ,    "beq_beq");
        add(OP_ADDI, 6'd0, 1'b1, 4'd0, C_F_RDY, "addi_fetch");
        add(OP_ADDI, 6'd0, 1'b0, 4'd1, C_DEC,   "addi_decode");
        add(OP_ADDI, 6'd0, 1'b0, 4'd9, C_ADR,   "addi_exec");
        add(OP_ADDI, 6'd0, 1'b0, 4'd10, C_IWB,  "addi_wb");
        add(OP_J, 6'd0, 1'b1, 4'd0, C_F_RDY,    "j_fetch");
        add(OP_J, 6'd0, 1'b0, 4'd1, C_DEC,      "j_decode");
        add(OP_J, 6'd0, 1'b0, 4'd11, C_JMP,     "j_jump");
        // watchdog expiry in FETCH on the 5th wait, then a normal fetch of an illegal OP
        for (int i = 0; i < 4; i++)
            add(OP_BAD, 6'd0, 1'b0, 4'd0, C_F_WAIT, "wd_wait");
        add(OP_BAD, 6'd0, 1'b0, 4'd0, C_F_BERR,  "wd_expire");
        add(OP_BAD, 6'd0, 1'b1, 4'd0, C_F_RDY,   "wd_retry");
        add(OP_BAD, 6'd0, 1'b0, 4'd1, C_DEC_ILL, "ill_decode");
        // ready arriving in the expiry cycle completes normally
        for (int i = 0; i < 4; i++)
            add(OP_J, 6'd0, 1'b0, 4'd0, C_F_WAIT, "wd2_wait");
        add(OP_J, 6'd0, 1'b1, 4'd0, C_F_RDY,  "wd2_ready");
        add(OP_J, 6'd0, 1'b0, 4'd1, C_DEC,    "wd2_decode");
        add(OP_J, 6'd0, 1'b0, 4'd11, C_JMP,   "wd2_jump");

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        compare("reset", 4'd0, C_ZERO);
        @(negedge CLK);
        RST = 1'b1;

        foreach (vecs[i])
            cycle(vecs[i].op, vecs[i].funct, vecs[i].rdy, vecs[i].st, vecs[i].ctl, vecs[i].name);

        // Asynchronous reset in the middle of a store
        cycle(OP_SW, 6'd0, 1'b1, 4'd0, C_F_RDY, "rs_fetch");
        cycle(OP_SW, 6'd0, 1'b0, 4'd1, C_DEC,   "rs_decode");
        cycle(OP_SW, 6'd0, 1'b0, 4'd2, C_ADR,   "rs_memadr");
        cycle(OP_SW, 6'd0, 1'b0, 4'd5, C_MWR,   "rs_memwr");
        #2;
        RST = 1'b0;
        #1;
        compare("rs_async", 4'd0, C_ZERO);
        $display("cycle %-14s state=%0d ctl=%b", "rs_async", STATE, ctl);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        compare("rs_release", 4'd0, C_F_WAIT);
        cycle(OP_J, 6'd0, 1'b1, 4'd0, C_F_RDY, "rs_refetch");
        cycle(OP_J, 6'd0, 1'b0, 4'd1, C_DEC,   "rs_decode2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
